// File: rtl/dds_channel_scheduler_if.sv
// Stream bundle between the channel scheduler, the shared dds core and the sample sink.
// No ready signals: every beat with tvalid=1 is a completed transfer, the sink must accept it.
interface dds_channel_scheduler_if #(
  parameter int PHASE_DW = 16,
  parameter int OUT_DW   = 16,
  parameter int CH_W     = 2
);
  logic [PHASE_DW-1:0] m_axis_phase_tdata;
  logic                m_axis_phase_tvalid;
  logic [2*OUT_DW-1:0] s_axis_dds_tdata;
  logic                s_axis_dds_tvalid;
  logic [2*OUT_DW-1:0] m_axis_out_tdata;
  logic [CH_W-1:0]     m_axis_out_tuser;
  logic                m_axis_out_tvalid;

  modport master (
    output m_axis_phase_tdata, m_axis_phase_tvalid,
    input  s_axis_dds_tdata, s_axis_dds_tvalid,
    output m_axis_out_tdata, m_axis_out_tuser, m_axis_out_tvalid
  );

  modport slave (
    input  m_axis_phase_tdata, m_axis_phase_tvalid,
    output s_axis_dds_tdata, s_axis_dds_tvalid,
    input  m_axis_out_tdata, m_axis_out_tuser, m_axis_out_tvalid
  );
endinterface

// File: rtl/dds_channel_scheduler.sv
// Round-robin time-multiplexer of one dds core across NUM_CH NCO channels, with a
// channel-id tag line matched to the dds latency so returned samples carry their channel.
module dds_channel_scheduler #(
  parameter int  PHASE_DW    = 16,
  parameter int  OUT_DW      = 16,
  parameter int  NUM_CH      = 4,
  parameter int  DDS_LATENCY = 9,
  localparam int CH_W        = $clog2(NUM_CH)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cfg_wr,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [PHASE_DW-1:0] cfg_ftw,
  input  logic [PHASE_DW-1:0] cfg_poff,
  input  logic [NUM_CH-1:0]   ch_enable,
  input  logic                run,
  input  logic                sync_req,
  dds_channel_scheduler_if.master bus,
  output logic                busy,
  output logic                tag_err,
  output logic [1:0]          state_dbg
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_SYNC = 2'd2} state_t;

  state_t              state_q, state_d;
  logic [PHASE_DW-1:0] acc_q [NUM_CH];
  logic [PHASE_DW-1:0] acc_d [NUM_CH];
  logic [PHASE_DW-1:0] ftw_q [NUM_CH];
  logic [PHASE_DW-1:0] ftw_d [NUM_CH];
  logic [PHASE_DW-1:0] poff_q [NUM_CH];
  logic [PHASE_DW-1:0] poff_d [NUM_CH];
  logic [CH_W-1:0]     rr_q, rr_d;
  logic [PHASE_DW-1:0] phase_q, phase_d;
  logic                phase_vld_q, phase_vld_d;
  logic [CH_W-1:0]     phase_ch_q, phase_ch_d;
  logic [CH_W:0]       tag_q [DDS_LATENCY];
  logic [CH_W:0]       tag_d [DDS_LATENCY];
  logic [2*OUT_DW-1:0] out_data_q, out_data_d;
  logic [CH_W-1:0]     out_user_q, out_user_d;
  logic                out_vld_q, out_vld_d;
  logic                tag_err_q, tag_err_d;

  logic                found;
  logic [CH_W-1:0]     sel;
  logic                tag_any;
  int                  idx;

  // Cyclic search for the first enabled channel at or after the round-robin pointer.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = int'(rr_q) + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!found && ch_enable[CH_W'(idx)]) begin
        found = 1'b1;
        sel   = CH_W'(idx);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    ftw_d       = ftw_q;
    poff_d      = poff_q;
    rr_d        = rr_q;
    phase_d     = phase_q;
    phase_vld_d = 1'b0;
    phase_ch_d  = phase_ch_q;
    case (state_q)
      S_IDLE: if (run && (|ch_enable)) state_d = S_RUN;
      S_RUN: begin
        if (!run || !(|ch_enable)) state_d = S_IDLE;
        if (found) begin
          phase_d     = acc_q[sel] + poff_q[sel];
          phase_vld_d = 1'b1;
          phase_ch_d  = sel;
          acc_d[sel]  = acc_q[sel] + ftw_q[sel];
          rr_d        = (int'(sel) == NUM_CH - 1) ? '0 : sel + CH_W'(1);
        end
      end
      S_SYNC: begin
        for (int i = 0; i < NUM_CH; i++) acc_d[i] = '0;
        rr_d    = '0;
        state_d = (run && (|ch_enable)) ? S_RUN : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (sync_req) state_d = S_SYNC;
    // Config lands after the issue above, so a same-cycle slot still sees the old words.
    if (cfg_wr && (int'(cfg_ch) < NUM_CH)) begin
      ftw_d[cfg_ch]  = cfg_ftw;
      poff_d[cfg_ch] = cfg_poff;
    end
  end

  always_comb begin
    tag_d[0] = {phase_vld_q, phase_ch_q};
    for (int k = 1; k < DDS_LATENCY; k++) tag_d[k] = tag_q[k-1];
    tag_any = 1'b0;
    for (int k = 0; k < DDS_LATENCY; k++) tag_any = tag_any | tag_q[k][CH_W];
    out_vld_d  = bus.s_axis_dds_tvalid;
    out_data_d = bus.s_axis_dds_tvalid ? bus.s_axis_dds_tdata : out_data_q;
    out_user_d = bus.s_axis_dds_tvalid ? tag_q[DDS_LATENCY-1][CH_W-1:0] : out_user_q;
    tag_err_d  = tag_err_q | (tag_q[DDS_LATENCY-1][CH_W] != bus.s_axis_dds_tvalid);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      rr_q        <= '0;
      phase_q     <= '0;
      phase_vld_q <= 1'b0;
      phase_ch_q  <= '0;
      out_data_q  <= '0;
      out_user_q  <= '0;
      out_vld_q   <= 1'b0;
      tag_err_q   <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        acc_q[i]  <= '0;
        ftw_q[i]  <= '0;
        poff_q[i] <= '0;
      end
      for (int k = 0; k < DDS_LATENCY; k++) tag_q[k] <= '0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      phase_q     <= phase_d;
      phase_vld_q <= phase_vld_d;
      phase_ch_q  <= phase_ch_d;
      out_data_q  <= out_data_d;
      out_user_q  <= out_user_d;
      out_vld_q   <= out_vld_d;
      tag_err_q   <= tag_err_d;
      acc_q       <= acc_d;
      ftw_q       <= ftw_d;
      poff_q      <= poff_d;
      tag_q       <= tag_d;
    end
  end

  assign bus.m_axis_phase_tdata  = phase_q;
  assign bus.m_axis_phase_tvalid = phase_vld_q;
  assign bus.m_axis_out_tdata    = out_data_q;
  assign bus.m_axis_out_tuser    = out_user_q;
  assign bus.m_axis_out_tvalid   = out_vld_q;
  assign busy      = (state_q != S_IDLE) || phase_vld_q || tag_any;
  assign tag_err   = tag_err_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_dds_channel_scheduler.sv
// Randomized scoreboard bench: a transaction-level channel model predicts every issued
// phase and every returned (channel, sample) beat; monitors compare what the DUT presents.
module tb_dds_channel_scheduler;
  localparam int NCH = 4;
  localparam int CW  = 2;
  localparam int D   = 9;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            cfg_wr = 1'b0;
  logic [CW-1:0]   cfg_ch = '0;
  logic [15:0]     cfg_ftw = '0;
  logic [15:0]     cfg_poff = '0;
  logic [NCH-1:0]  ch_enable = '0;
  logic            run = 1'b0;
  logic            sync_req = 1'b0;
  logic            busy, tag_err;
  logic [1:0]      state_dbg;

  dds_channel_scheduler_if #(.PHASE_DW(16), .OUT_DW(16), .CH_W(CW)) bus ();

  dds_channel_scheduler #(.PHASE_DW(16), .OUT_DW(16), .NUM_CH(NCH), .DDS_LATENCY(D)) dut (
    .clk(clk), .reset_n(reset_n), .cfg_wr(cfg_wr), .cfg_ch(cfg_ch), .cfg_ftw(cfg_ftw),
    .cfg_poff(cfg_poff), .ch_enable(ch_enable), .run(run), .sync_req(sync_req),
    .bus(bus), .busy(busy), .tag_err(tag_err), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Expected queues: phase entries {cycle, phase}; out entries {tuser_dont_care, cycle, ch, data}.
  logic [47:0] phase_exp_q[$];
  logic [66:0] out_exp_q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  // Stand-in for the dds: any fixed phase->sample map lets ids and data be verified end to end.
  function automatic logic [31:0] dds_fn(input logic [15:0] p);
    return {p ^ 16'h5A5A, p + 16'h1234};
  endfunction

  // ---------------- reference model (one step per clock) ----------------
  logic [15:0] m_acc [NCH];
  logic [15:0] m_ftw [NCH];
  logic [15:0] m_poff [NCH];
  logic [CW-1:0] m_rr;
  bit m_running, m_sync_now;
  logic [CW-1:0] c;
  logic [15:0] ph;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!reset_n) begin
      for (int i = 0; i < NCH; i++) begin m_acc[i] = '0; m_ftw[i] = '0; m_poff[i] = '0; end
      m_rr = '0; m_running = 0; m_sync_now = 0;
      phase_exp_q.delete();
      out_exp_q.delete();
    end else begin
      if (m_sync_now) begin
        for (int i = 0; i < NCH; i++) m_acc[i] = '0;
        m_rr = '0;
      end else if (m_running) begin
        for (int i = 0; i < NCH; i++) begin
          c = m_rr + CW'(i);
          if (ch_enable[c]) begin
            ph = m_acc[c] + m_poff[c];
            phase_exp_q.push_back({32'(cyc), ph});
            out_exp_q.push_back({1'b0, 32'(cyc + D + 1), c, dds_fn(ph)});
            m_acc[c] = m_acc[c] + m_ftw[c];
            m_rr = c + CW'(1);
            break;
          end
        end
      end
      if (cfg_wr) begin m_ftw[cfg_ch] = cfg_ftw; m_poff[cfg_ch] = cfg_poff; end
      m_sync_now = sync_req;
      m_running  = run && (ch_enable != '0) && !sync_req;
    end
  end

  // ---------------- dds stand-in + monitors ----------------
  logic        pipe_v [D];
  logic [15:0] pipe_d [D];
  bit          inject = 0;
  logic [47:0] pe;
  logic [66:0] oe;

  initial begin
    bus.s_axis_dds_tvalid = 1'b0;
    bus.s_axis_dds_tdata  = '0;
  end

  always @(negedge clk) begin
    if (!reset_n) begin
      chk("reset_outs", {bus.m_axis_phase_tvalid, bus.m_axis_out_tvalid, bus.m_axis_phase_tdata,
                         bus.m_axis_out_tdata, bus.m_axis_out_tuser, busy, tag_err}, 64'd0);
      phase_exp_q.delete();
      out_exp_q.delete();
      for (int i = 0; i < D; i++) begin pipe_v[i] = 1'b0; pipe_d[i] = '0; end
      bus.s_axis_dds_tvalid = 1'b0;
      bus.s_axis_dds_tdata  = '0;
    end else begin
      if (bus.m_axis_phase_tvalid) begin
        if (phase_exp_q.size() == 0) chk("phase_unexpected", 64'(bus.m_axis_phase_tdata), 64'hFFFF_FFFF_FFFF_FFFF);
        else begin
          pe = phase_exp_q.pop_front();
          chk("phase_cyc_data", 64'({32'(cyc), bus.m_axis_phase_tdata}), 64'(pe));
        end
      end else if (phase_exp_q.size() != 0 && int'(phase_exp_q[0][47:16]) <= cyc) begin
        pe = phase_exp_q.pop_front();
        chk("phase_missing", 64'(0), 64'(pe));
      end
      if (bus.m_axis_out_tvalid) begin
        if (out_exp_q.size() == 0) chk("out_unexpected", 64'(bus.m_axis_out_tdata), 64'hFFFF_FFFF_FFFF_FFFF);
        else begin
          oe = out_exp_q.pop_front();
          if (oe[66]) oe[33:32] = bus.m_axis_out_tuser;
          chk("out_cyc", 64'(cyc), 64'(oe[65:34]));
          chk("out_user_data", 64'({bus.m_axis_out_tuser, bus.m_axis_out_tdata}), 64'(oe[33:0]));
        end
      end else if (out_exp_q.size() != 0 && int'(out_exp_q[0][65:34]) <= cyc) begin
        oe = out_exp_q.pop_front();
        chk("out_missing", 64'(0), 64'(oe[33:0]));
      end
      if (inject) begin
        bus.s_axis_dds_tvalid = 1'b1;
        bus.s_axis_dds_tdata  = 32'hDEAD_BEEF;
        out_exp_q.push_back({1'b1, 32'(cyc + 1), 2'b00, 32'hDEAD_BEEF});
        inject = 0;
      end else begin
        bus.s_axis_dds_tvalid = pipe_v[D-1];
        bus.s_axis_dds_tdata  = dds_fn(pipe_d[D-1]);
      end
      for (int i = D - 1; i > 0; i--) begin pipe_v[i] = pipe_v[i-1]; pipe_d[i] = pipe_d[i-1]; end
      pipe_v[0] = bus.m_axis_phase_tvalid;
      pipe_d[0] = bus.m_axis_phase_tdata;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cfg(input int ch, input logic [15:0] f, input logic [15:0] p);
    @(negedge clk);
    cfg_wr = 1'b1; cfg_ch = CW'(ch); cfg_ftw = f; cfg_poff = p;
    @(negedge clk);
    cfg_wr = 1'b0;
  endtask

  task automatic pulse_sync();
    @(negedge clk);
    sync_req = 1'b1;
    @(negedge clk);
    sync_req = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(3);
    reset_n = 1'b1;
    tick(2);
    chk("idle_busy", 64'(busy), 64'd0);

    // ftw 1..4, all enabled: order 0,1,2,3 and ch2 phases 0,3,6,...
    for (int i = 0; i < NCH; i++) cfg(i, 16'(i + 1), 16'h0000);
    ch_enable = 4'hF;
    run = 1'b1;
    tick(3);
    chk("run_busy", 64'(busy), 64'd1);
    tick(20);

    // Sparse mask: only ch1/ch3 advance, ch0/ch2 stay frozen until re-enabled
    ch_enable = 4'b1010;
    tick(12);
    ch_enable = 4'b0101;
    tick(8);

    // Single channel with wrap-around arithmetic
    run = 1'b0;
    cfg(0, 16'hC000, 16'h8000);
    pulse_sync();
    ch_enable = 4'b0001;
    run = 1'b1;
    tick(8);

    // Sync while running with random words: every channel restarts at its offset
    ch_enable = 4'hF;
    for (int i = 0; i < NCH; i++) cfg(i, 16'($urandom), 16'($urandom));
    tick(10);
    pulse_sync();
    tick(10);

    // Config hitting the channel being issued that very cycle
    ch_enable = 4'b0100;
    tick(4);
    cfg(2, 16'h0100, 16'h0010);
    tick(6);

    // Sync and config in the same cycle
    ch_enable = 4'hF;
    @(negedge clk);
    sync_req = 1'b1; cfg_wr = 1'b1; cfg_ch = 2'd1; cfg_ftw = 16'h0777; cfg_poff = 16'h1111;
    @(negedge clk);
    sync_req = 1'b0; cfg_wr = 1'b0;
    tick(8);

    // Random traffic
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      run      = ($urandom_range(0, 9) != 0);
      sync_req = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 7) == 0) ch_enable = 4'($urandom_range(0, 15));
      cfg_wr   = ($urandom_range(0, 3) == 0);
      cfg_ch   = 2'($urandom_range(0, NCH - 1));
      cfg_ftw  = 16'($urandom);
      cfg_poff = 16'($urandom);
    end
    @(negedge clk);
    run = 1'b0; sync_req = 1'b0; cfg_wr = 1'b0;
    tick(D + 4);
    chk("drained_busy", 64'(busy), 64'd0);
    chk("tag_err_clean", 64'(tag_err), 64'd0);

    // Spurious dds beat with an empty tag line: sticky error
    inject = 1;
    tick(3);
    chk("tag_err_set", 64'(tag_err), 64'd1);
    tick(6);
    chk("tag_err_sticky", 64'(tag_err), 64'd1);

    // Reset in the middle of a run with samples in flight
    ch_enable = 4'hF;
    run = 1'b1;
    tick(D + 3);
    @(posedge clk);
    #1 reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    tick(1);
    chk("tag_err_after_reset", 64'(tag_err), 64'd0);
    tick(20);
    run = 1'b0;
    tick(D + 4);
    chk("final_busy", 64'(busy), 64'd0);
    chk("final_tag_err", 64'(tag_err), 64'd0);
    chk("phase_q_empty", 64'(phase_exp_q.size()), 64'd0);
    chk("out_q_empty", 64'(out_exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
